// File: rtl/ir_pkg.sv
// Shared NEC IR constants, scheduler state encoding and frame-word helper.
package ir_pkg;

  localparam int unsigned CLK_HZ               = 12_000_000;
  localparam int unsigned NEC_FRAME_PERIOD_CYC = (CLK_HZ / 1000) * 110;
  localparam int unsigned NEC_BUSY_TIMEOUT_CYC = 16;
  // AGC leader timing shared with the bit encoder (9 ms burst, 4.5 ms / 2.25 ms pause)
  localparam int unsigned NEC_AGC_BURST_CYC    = (CLK_HZ / 1000) * 9;
  localparam int unsigned NEC_AGC_PAUSE_CYC    = (CLK_HZ / 2000) * 9;
  localparam int unsigned NEC_RPT_PAUSE_CYC    = (CLK_HZ / 4000) * 9;

  localparam int unsigned ST_W = 3;
  localparam logic [ST_W-1:0] ST_IDLE      = 3'd0;
  localparam logic [ST_W-1:0] ST_ARB       = 3'd1;
  localparam logic [ST_W-1:0] ST_GAP       = 3'd2;
  localparam logic [ST_W-1:0] ST_LAUNCH    = 3'd3;
  localparam logic [ST_W-1:0] ST_WAIT_BUSY = 3'd4;
  localparam logic [ST_W-1:0] ST_WAIT_DONE = 3'd5;

  localparam logic KIND_FULL = 1'b0;
  localparam logic KIND_RPT  = 1'b1;

  function automatic logic [31:0] nec_frame(input logic [7:0] addr, input logic [7:0] cmd);
    return {~cmd, cmd, ~addr, addr};
  endfunction

endpackage

// File: rtl/ir_rr_arb2.sv
// Two-way round-robin arbiter: on contention the requester not granted last time wins.
module ir_rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic       grant_c,
  output logic       any_c
);

  always_comb begin
    any_c   = |valid;
    grant_c = valid[1];
    if (valid == 2'b11) grant_c = ~last_grant;
  end

endmodule

// File: rtl/ir_tx_scheduler.sv
// NEC IR transmit scheduler: arbitrates two requesters, builds the frame word,
// paces launches to the NEC frame period and issues repeat codes while a key is held.
module ir_tx_scheduler
  import ir_pkg::*;
#(
  parameter int unsigned FRAME_PERIOD_CYC = NEC_FRAME_PERIOD_CYC,
  parameter int unsigned BUSY_TIMEOUT_CYC = NEC_BUSY_TIMEOUT_CYC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [7:0]  req_addr0,
  input  logic [7:0]  req_cmd0,
  input  logic [7:0]  req_addr1,
  input  logic [7:0]  req_cmd1,
  input  logic [1:0]  req_repeat,
  output logic        tx_start,
  output logic [31:0] tx_frame,
  output logic        tx_repeat,
  input  logic        tx_busy,
  output logic        grant_id,
  output logic        sched_busy,
  output logic        err_timeout
);

  localparam int unsigned PER_W = $clog2(FRAME_PERIOD_CYC + 1);
  localparam int unsigned TO_W  = $clog2(BUSY_TIMEOUT_CYC + 1);
  localparam logic [PER_W-1:0] PER_MAX  = PER_W'(FRAME_PERIOD_CYC);
  localparam logic [PER_W-1:0] PER_PRE  = PER_W'(FRAME_PERIOD_CYC - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(BUSY_TIMEOUT_CYC - 1);

  logic [ST_W-1:0]  state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             grant_q, grant_d;
  logic             kind_q, kind_d;
  logic             repeat_active_q, repeat_active_d;
  logic [PER_W-1:0] per_cnt_q, per_cnt_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [31:0]      frame_q, frame_d;
  logic [1:0]       req_ready_q, req_ready_d;
  logic             tx_start_q, tx_start_d;
  logic             tx_repeat_q, tx_repeat_d;
  logic             sched_busy_q, sched_busy_d;
  logic             err_timeout_q, err_timeout_d;

  logic arb_grant;
  logic arb_any;
  logic period_ok;
  logic launch_ok;

  ir_rr_arb2 u_arb (
    .valid      (req_valid),
    .last_grant (last_grant_q),
    .grant_c    (arb_grant),
    .any_c      (arb_any)
  );

  assign period_ok = (per_cnt_q == PER_MAX);
  // tx_start is registered, so decide one cycle early to keep launches exactly one period apart
  assign launch_ok = period_ok || (per_cnt_q == PER_PRE);

  always_comb begin
    state_d         = state_q;
    last_grant_d    = last_grant_q;
    grant_d         = grant_q;
    kind_d          = kind_q;
    repeat_active_d = repeat_active_q;
    frame_d         = frame_q;
    tx_repeat_d     = tx_repeat_q;
    req_ready_d     = 2'b00;
    tx_start_d      = 1'b0;
    err_timeout_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          // Grant resolves on ARB entry so the registered ready strobe lands in ARB
          state_d      = ST_ARB;
          req_ready_d  = arb_grant ? 2'b10 : 2'b01;
          grant_d      = arb_grant;
          last_grant_d = arb_grant;
          kind_d       = KIND_FULL;
          frame_d      = arb_grant ? nec_frame(req_addr1, req_cmd1)
                                   : nec_frame(req_addr0, req_cmd0);
        end else if (repeat_active_q && req_repeat[grant_q]) begin
          state_d = ST_GAP;
        end else begin
          repeat_active_d = 1'b0;
        end
      end
      ST_ARB: state_d = ST_GAP;
      ST_GAP: begin
        if (kind_q == KIND_RPT && (!req_repeat[grant_q] || (|req_valid))) begin
          state_d = ST_IDLE;
        end else if (launch_ok && !tx_busy) begin
          state_d     = ST_LAUNCH;
          tx_start_d  = 1'b1;
          tx_repeat_d = kind_q;
        end
      end
      ST_LAUNCH: state_d = ST_WAIT_BUSY;
      ST_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (to_cnt_q == TO_LAST) begin
          state_d         = ST_IDLE;
          err_timeout_d   = 1'b1;
          repeat_active_d = 1'b0;
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) begin
          state_d         = ST_IDLE;
          repeat_active_d = req_repeat[grant_q];
          kind_d          = KIND_RPT;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    sched_busy_d = (state_d != ST_IDLE);

    if (tx_start_d)               per_cnt_d = '0;
    else if (per_cnt_q == PER_MAX) per_cnt_d = per_cnt_q;
    else                          per_cnt_d = per_cnt_q + PER_W'(1);

    if (tx_start_d)
      to_cnt_d = '0;
    else if (state_q == ST_LAUNCH || state_q == ST_WAIT_BUSY)
      to_cnt_d = to_cnt_q + TO_W'(1);
    else
      to_cnt_d = to_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      last_grant_q    <= 1'b1;
      grant_q         <= 1'b0;
      kind_q          <= KIND_FULL;
      repeat_active_q <= 1'b0;
      per_cnt_q       <= PER_MAX;
      to_cnt_q        <= '0;
      frame_q         <= '0;
      req_ready_q     <= 2'b00;
      tx_start_q      <= 1'b0;
      tx_repeat_q     <= 1'b0;
      sched_busy_q    <= 1'b0;
      err_timeout_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      last_grant_q    <= last_grant_d;
      grant_q         <= grant_d;
      kind_q          <= kind_d;
      repeat_active_q <= repeat_active_d;
      per_cnt_q       <= per_cnt_d;
      to_cnt_q        <= to_cnt_d;
      frame_q         <= frame_d;
      req_ready_q     <= req_ready_d;
      tx_start_q      <= tx_start_d;
      tx_repeat_q     <= tx_repeat_d;
      sched_busy_q    <= sched_busy_d;
      err_timeout_q   <= err_timeout_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign tx_start    = tx_start_q;
  assign tx_frame    = frame_q;
  assign tx_repeat   = tx_repeat_q;
  assign grant_id    = grant_q;
  assign sched_busy  = sched_busy_q;
  assign err_timeout = err_timeout_q;

endmodule

// File: doc/ir_tx_scheduler.md
Name: ir_tx_scheduler

Overview:
- Sequences the NEC IR transmit datapath: picks one of two requesters (round-robin), builds the 32-bit NEC frame word, and launches the bit-level encoder/38 kHz modulator through a start/busy handshake.
- Issues NEC repeat codes while the owning requester holds its repeat line, and enforces the NEC frame period between launches.
- Sits between the command sources (buttons/UART decoder) and the existing NEC encoder that drives TXD.

Parameters:
- FRAME_PERIOD_CYC, 1320000, minimum cycles between successive tx_start pulses (110 ms at 12 MHz).
- BUSY_TIMEOUT_CYC, 16, max cycles from tx_start to tx_busy rising before abort.
- PER_W, $clog2(FRAME_PERIOD_CYC+1), period counter width (derived, not overridden).

Ports:
- clk  in  1  system clock, 12 MHz.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  2  per-requester frame request.
- req_ready  out  2  one-cycle accept strobe per requester.
- req_addr0  in  8  requester 0 NEC address.
- req_cmd0  in  8  requester 0 NEC command.
- req_addr1  in  8  requester 1 NEC address.
- req_cmd1  in  8  requester 1 NEC command.
- req_repeat  in  2  per-requester "key held": request repeat codes after the accepted frame.
- tx_start  out  1  one-cycle launch pulse to encoder.
- tx_frame  out  32  frame word, transmitted LSB first.
- tx_repeat  out  1  1 = send repeat code (9 ms burst, 2.25 ms pause, stop bit); tx_frame ignored.
- tx_busy  in  1  encoder busy; rises after tx_start, falls when the frame completes.
- grant_id  out  1  current/last owner.
- sched_busy  out  1  high in any state except IDLE.
- err_timeout  out  1  one-cycle pulse on busy-timeout abort.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low, named rst_n.
- Reset values: all outputs 0; state IDLE; last_grant=1 (requester 0 wins first); period counter saturated (launch allowed immediately); repeat_active=0. Reset mid-frame aborts at once; the encoder is reset by the same rst_n.
- Frame word: tx_frame = {~cmd, cmd, ~addr, addr}.
  - bit0 = addr[0].
  - Example: addr 0x04, cmd 0xFF gives 0x00FFFB04.
  - Captured into a register on acceptance; held stable until the next acceptance.
- Period counter:
  - Cleared to 0 on each tx_start, then increments each cycle.
  - Saturates at FRAME_PERIOD_CYC.
  - period_ok = (counter == FRAME_PERIOD_CYC).
- States:
  - IDLE:
    - If any req_valid → ARB.
    - Else if repeat_active and req_repeat[grant_id] → GAP (repeat pending).
    - Else repeat_active ← 0.
  - ARB (1 cycle):
    - Both valid → grant ~last_grant. Otherwise grant the valid one.
    - Pulse req_ready[g]; capture addr/cmd; grant_id ← g; last_grant ← g; kind ← full.
    - → GAP.
  - GAP:
    - Wait for period_ok.
    - A repeat launch is cancelled (→ IDLE) if req_repeat[grant_id] drops or any req_valid rises before period_ok.
    - When period_ok → LAUNCH.
  - LAUNCH (1 cycle): tx_start=1; tx_repeat=(kind==repeat) → WAIT_BUSY.
  - WAIT_BUSY:
    - tx_busy=1 → WAIT_DONE.
    - After BUSY_TIMEOUT_CYC cycles without busy: err_timeout pulse, repeat_active ← 0 → IDLE.
  - WAIT_DONE:
    - On tx_busy falling → IDLE.
    - repeat_active ← req_repeat[grant_id]; kind ← repeat.
- Priority: a new req_valid (either requester) always pre-empts pending repeats. Repeats continue only for the current owner.
- req_ready is never asserted outside ARB and is never asserted to both requesters at once.
- Requesters must hold addr/cmd stable while req_valid is high. A request dropped before ARB is simply not served.
- tx_busy asserted while in IDLE/GAP: ignored. Scheduler does not launch while tx_busy=1 (LAUNCH is gated by period_ok && !tx_busy).

Decomposition:
- Shared package ir_pkg:
  - State encoding enum.
  - NEC timing constants: CLK_HZ=12000000, FRAME_PERIOD_CYC, AGC burst/pause cycle counts shared with the encoder.
  - Function nec_frame(addr,cmd) returning the 32-bit word.
- One natural sub-module: ir_rr_arb2 (2-way round-robin arbiter: valid[1:0], last_grant → grant, any).

Test Plan:
- Single request: req_valid[0], addr 0x04, cmd 0xFF → req_ready[0] one cycle; tx_start one cycle; tx_frame=0x00FFFB04; tx_repeat=0.
- Both valid after reset:
  - First grant is requester 0 (addr 0x10/cmd 0x01 → 0xFE01EF10).
  - Next grant is requester 1.
  - tx_start pulses ≥ FRAME_PERIOD_CYC apart.
- Repeat hold: req_repeat[0]=1 for 3 periods after the frame → three tx_start pulses with tx_repeat=1, spaced exactly FRAME_PERIOD_CYC (encoder busy model shorter than period); release → no further starts.
- Pre-empt: repeats active on requester 0, req_valid[1] with cmd 0x22 → next launch is a full frame for requester 1; no repeat emitted; grant_id=1.
- Timeout: tx_busy held 0 after tx_start → err_timeout pulse at cycle BUSY_TIMEOUT_CYC; state IDLE; sched_busy=0.
- Reset mid-frame: rst_n low during WAIT_DONE → all outputs 0 asynchronously; after release, first launch is allowed immediately and requester 0 has priority.
